// File: rtl/dm_dtm_pkg.sv
// Shared types and constants for the DTM data-register stage (DTMCS / DMI access).
package dm_dtm_pkg;

   typedef enum logic [1:0] {
      OpNop   = 2'd0,
      OpRead  = 2'd1,
      OpWrite = 2'd2,
      OpRsvd  = 2'd3
   } dtm_op_e;

   typedef enum logic [1:0] {
      StatusOk     = 2'd0,
      StatusFailed = 2'd2,
      StatusBusy   = 2'd3
   } dmi_status_e;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWaitRead,
      StWrite,
      StWaitWrite
   } dtm_state_e;

   localparam logic [3:0] DtmcsVersion = 4'd1;

   localparam int DmiReset     = 16;
   localparam int DmiHardReset = 17;

   // Capture image of DTMCS; the two reset bits always read back as zero.
   function automatic logic [31:0] dtmcsWord(input logic [2:0] idle,
                                             input logic [1:0] stat,
                                             input logic [5:0] abits);
      return {14'b0, 1'b0, 1'b0, 1'b0, idle, stat, abits, DtmcsVersion};
   endfunction

endpackage

// File: rtl/dtm_shift_reg.sv
// JTAG data register: parallel load on capture, LSB-first serial shift, LSB drives TDO.
module dtm_shift_reg #(
   parameter int Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic             tdi_i,
   input  logic [Width-1:0] load_i,
   output logic [Width-1:0] data_o,
   output logic             tdo_o
);

   logic [Width-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (capture_i) begin
         sr_d = load_i;
      end else if (shift_i) begin
         sr_d = {tdi_i, sr_q[Width-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign data_o = sr_q;
   assign tdo_o  = sr_q[0];

endmodule

// File: rtl/dmi_jtag_dr.sv
// DTMCS and DMI access registers of the DTM, turning DMI updates into DMI requests.
// Define DMI_TIMEOUT_EN to add a response watchdog of TimeoutCycles wait cycles.
module dmi_jtag_dr
   import dm_dtm_pkg::*;
#(
   parameter int AddrWidth     = 7,
   parameter int IdleCycles    = 1,
   parameter int TimeoutCycles = 1024
) (
   input  logic                 tck_i,
   input  logic                 trst_i,
   input  logic                 capture_i,
   input  logic                 shift_i,
   input  logic                 update_i,
   input  logic                 tdi_i,
   input  logic                 dtmcs_select_i,
   input  logic                 dmi_select_i,
   output logic                 dtmcs_tdo_o,
   output logic                 dmi_tdo_o,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [AddrWidth-1:0] dmi_req_addr_o,
   output logic [31:0]          dmi_req_data_o,
   output logic [1:0]           dmi_req_op_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [31:0]          dmi_resp_data_i,
   input  logic                 dmi_resp_err_i
);

   localparam int DmiWidth = AddrWidth + 34;
   localparam logic [2:0] IdleField = (IdleCycles > 7) ? 3'd7 : 3'(IdleCycles);

   dtm_state_e           state_q, state_d;
   logic [1:0]           error_q, error_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [31:0]          data_q, data_d;

   logic [31:0]          dtmcsShift;
   logic [DmiWidth-1:0]  dmiShift;
   logic                 unusedDtmcs;

   logic dtmcsCapture, dtmcsShiftEn, dtmcsUpdate;
   logic dmiCapture, dmiShiftEn, dmiUpdate;
   logic hardReset, dmiResetReq;
   logic busy, waitState, respDone, timeout;
   logic startRead, startWrite, busyUpdate, busyCapture;

   assign dtmcsCapture = capture_i & dtmcs_select_i;
   assign dtmcsShiftEn = shift_i & dtmcs_select_i;
   assign dtmcsUpdate  = update_i & dtmcs_select_i;
   assign dmiCapture   = capture_i & dmi_select_i;
   assign dmiShiftEn   = shift_i & dmi_select_i;
   assign dmiUpdate    = update_i & dmi_select_i;

   assign hardReset   = dtmcsUpdate & dtmcsShift[DmiHardReset];
   assign dmiResetReq = dtmcsUpdate & dtmcsShift[DmiReset];
   assign unusedDtmcs = ^{dtmcsShift[31:18], dtmcsShift[15:0]};

   // Busy checks use the registered state, so an update in the return-to-Idle cycle is still busy.
   assign busy        = (state_q != StIdle);
   assign waitState   = (state_q == StWaitRead) | (state_q == StWaitWrite);
   assign respDone    = waitState & dmi_resp_valid_i;
   assign startRead   = dmiUpdate & (error_q == StatusOk) & ~busy & (dmiShift[1:0] == OpRead);
   assign startWrite  = dmiUpdate & (error_q == StatusOk) & ~busy & (dmiShift[1:0] == OpWrite);
   assign busyUpdate  = dmiUpdate & (error_q == StatusOk) & busy;
   assign busyCapture = dmiCapture & busy;

   dtm_shift_reg #(.Width(32)) u_dtmcs_sr (
      .clk_i     (tck_i),
      .rst_i     (trst_i),
      .capture_i (dtmcsCapture),
      .shift_i   (dtmcsShiftEn),
      .tdi_i     (tdi_i),
      .load_i    (dtmcsWord(IdleField, error_q, 6'(AddrWidth))),
      .data_o    (dtmcsShift),
      .tdo_o     (dtmcs_tdo_o)
   );

   dtm_shift_reg #(.Width(DmiWidth)) u_dmi_sr (
      .clk_i     (tck_i),
      .rst_i     (trst_i),
      .capture_i (dmiCapture),
      .shift_i   (dmiShiftEn),
      .tdi_i     (tdi_i),
      .load_i    ({addr_q, data_q, busy ? 2'(StatusBusy) : error_q}),
      .data_o    (dmiShift),
      .tdo_o     (dmi_tdo_o)
   );

`ifdef DMI_TIMEOUT_EN
   logic [15:0] waitCnt_q, waitCnt_d;

   // Counter is zero in the first wait cycle; the watchdog fires on its TimeoutCycles-th wait cycle.
   always_comb begin
      waitCnt_d = waitState ? waitCnt_q + 16'd1 : 16'd0;
   end

   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         waitCnt_q <= '0;
      end else begin
         waitCnt_q <= waitCnt_d;
      end
   end

   assign timeout = waitState & ~dmi_resp_valid_i & (waitCnt_q == 16'(TimeoutCycles - 1));
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TimeoutCycles;
   assign timeout       = 1'b0;
`endif

   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (startRead) begin
               state_d = StRead;
            end else if (startWrite) begin
               state_d = StWrite;
            end
         end
         StRead:      if (dmi_req_ready_i) state_d = StWaitRead;
         StWrite:     if (dmi_req_ready_i) state_d = StWaitWrite;
         StWaitRead,
         StWaitWrite: if (dmi_resp_valid_i || timeout) state_d = StIdle;
         default:     state_d = StIdle;
      endcase
      if (hardReset) begin
         state_d = StIdle;
      end
   end

   always_comb begin
      dmi_req_valid_o = 1'b0;
      dmi_req_op_o    = OpNop;
      case (state_q)
         StRead: begin
            dmi_req_valid_o = 1'b1;
            dmi_req_op_o    = OpRead;
         end
         StWrite: begin
            dmi_req_valid_o = 1'b1;
            dmi_req_op_o    = OpWrite;
         end
         default: ;
      endcase
   end

   assign dmi_req_addr_o   = addr_q;
   assign dmi_req_data_o   = data_q;
   assign dmi_resp_ready_o = 1'b1;

   // The first error sticks until DTMCS clears it; a clear wins over a same-cycle error.
   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      error_d = error_q;
      if (startRead || startWrite) begin
         addr_d = dmiShift[DmiWidth-1:34];
      end
      if (startWrite) begin
         data_d = dmiShift[33:2];
      end
      if (respDone && (state_q == StWaitRead)) begin
         data_d = dmi_resp_data_i;
      end
      if (error_q == StatusOk) begin
         if (busyCapture || busyUpdate) begin
            error_d = StatusBusy;
         end else if ((respDone && dmi_resp_err_i) || timeout) begin
            error_d = StatusFailed;
         end
      end
      if (dmiResetReq || hardReset) begin
         error_d = StatusOk;
      end
   end

   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         addr_q  <= '0;
         data_q  <= '0;
         error_q <= StatusOk;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed bench for dmi_jtag_dr: table of scan transactions plus busy, hard-reset and timeout sequences.
module tb_dmi_jtag_dr;

   localparam int AW = 7;

   logic          tck = 1'b0;
   logic          trst, capture, shift, update, tdi;
   logic          dtmcsSel, dmiSel;
   logic          dtmcsTdo, dmiTdo;
   logic          reqValid, reqReady;
   logic [AW-1:0] reqAddr;
   logic [31:0]   reqData;
   logic [1:0]    reqOp;
   logic          respValid, respReady, respErr;
   logic [31:0]   respData;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      bit          isDmi;
      logic [63:0] shiftIn;
      logic [63:0] expOut;
      bit          expValid;
      logic [1:0]  expOp;
      logic [6:0]  expAddr;
      logic [31:0] expData;
      int          respDelay;
      logic [31:0] rData;
      bit          rErr;
   } vec_t;

   vec_t vecs[9];

   dmi_jtag_dr #(.AddrWidth(AW), .IdleCycles(1), .TimeoutCycles(8)) dut (
      .tck_i            (tck),
      .trst_i           (trst),
      .capture_i        (capture),
      .shift_i          (shift),
      .update_i         (update),
      .tdi_i            (tdi),
      .dtmcs_select_i   (dtmcsSel),
      .dmi_select_i     (dmiSel),
      .dtmcs_tdo_o      (dtmcsTdo),
      .dmi_tdo_o        (dmiTdo),
      .dmi_req_valid_o  (reqValid),
      .dmi_req_ready_i  (reqReady),
      .dmi_req_addr_o   (reqAddr),
      .dmi_req_data_o   (reqData),
      .dmi_req_op_o     (reqOp),
      .dmi_resp_valid_i (respValid),
      .dmi_resp_ready_o (respReady),
      .dmi_resp_data_i  (respData),
      .dmi_resp_err_i   (respErr)
   );

   always #5 tck = ~tck;

   function automatic logic [63:0] dmiWord(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
      return {23'b0, a, d, op};
   endfunction

   function automatic vec_t mk(input string n, input bit dmi, input logic [63:0] sin,
                               input logic [63:0] eout, input bit ev, input logic [1:0] eop,
                               input logic [6:0] ea, input logic [31:0] ed, input int dly,
                               input logic [31:0] rd, input bit re);
      vec_t v;
      v.name = n; v.isDmi = dmi; v.shiftIn = sin; v.expOut = eout; v.expValid = ev;
      v.expOp = eop; v.expAddr = ea; v.expData = ed; v.respDelay = dly; v.rData = rd; v.rErr = re;
      return v;
   endfunction

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Full capture/shift/update scan of one data register; returns the bits shifted out.
   task automatic applyStimulus(input bit isDmi, input logic [63:0] din, output logic [63:0] dout);
      int w;
      w = isDmi ? AW + 34 : 32;
      dout = '0;
      dmiSel = isDmi;
      dtmcsSel = ~isDmi;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      shift = 1'b1;
      for (int i = 0; i < w; i++) begin
         dout[i] = isDmi ? dmiTdo : dtmcsTdo;
         tdi = din[i];
         tick();
      end
      shift = 1'b0;
      tdi = 1'b0;
      update = 1'b1;
      tick();
      update = 1'b0;
      dmiSel = 1'b0;
      dtmcsSel = 1'b0;
   endtask

   task automatic respond(input int dly, input logic [31:0] d, input logic e);
      repeat (dly) tick();
      respValid = 1'b1;
      respData = d;
      respErr = e;
      tick();
      respValid = 1'b0;
      respData = '0;
      respErr = 1'b0;
   endtask

   task automatic handshake();
      reqReady = 1'b1;
      tick();
      reqReady = 1'b0;
   endtask

   initial begin
      logic [63:0] out;
      trst = 1'b1; capture = 0; shift = 0; update = 0; tdi = 0;
      dtmcsSel = 0; dmiSel = 0; reqReady = 0; respValid = 0; respData = '0; respErr = 0;

      vecs[0] = mk("dtmcs_reset", 0, 64'd0, 64'h1071, 0, 2'd0, 7'h00, 32'h0, 0, 32'h0, 0);
      vecs[1] = mk("dmi_write", 1, dmiWord(7'h10, 32'h1, 2'd2), 64'd0,
                   1, 2'd2, 7'h10, 32'h1, 0, 32'h12345678, 0);
      vecs[2] = mk("dmi_read", 1, dmiWord(7'h11, 32'h0, 2'd1), dmiWord(7'h10, 32'h1, 2'd0),
                   1, 2'd1, 7'h11, 32'h1, 5, 32'hDEADBEEF, 0);
      vecs[3] = mk("dmi_readback", 1, 64'd0, dmiWord(7'h11, 32'hDEADBEEF, 2'd0),
                   0, 2'd0, 7'h00, 32'h0, 0, 32'h0, 0);
      vecs[4] = mk("dmi_write_err", 1, dmiWord(7'h05, 32'hCAFEF00D, 2'd2),
                   dmiWord(7'h11, 32'hDEADBEEF, 2'd0), 1, 2'd2, 7'h05, 32'hCAFEF00D, 2, 32'h0, 1);
      vecs[5] = mk("dtmcs_failed", 0, 64'd0, 64'h1871, 0, 2'd0, 7'h00, 32'h0, 0, 32'h0, 0);
      vecs[6] = mk("dmi_read_ignored", 1, dmiWord(7'h22, 32'h0, 2'd1),
                   dmiWord(7'h05, 32'hCAFEF00D, 2'd2), 0, 2'd0, 7'h00, 32'h0, 0, 32'h0, 0);
      vecs[7] = mk("dtmcs_dmireset", 0, 64'h10000, 64'h1871, 0, 2'd0, 7'h00, 32'h0, 0, 32'h0, 0);
      vecs[8] = mk("dtmcs_cleared", 0, 64'd0, 64'h1071, 0, 2'd0, 7'h00, 32'h0, 0, 32'h0, 0);

      tick();
      tick();
      trst = 1'b0;
      checkOutput("reset_req_valid", {63'd0, reqValid}, 64'd0);
      checkOutput("reset_resp_ready", {63'd0, respReady}, 64'd1);
      checkOutput("reset_tdo", {62'd0, dtmcsTdo, dmiTdo}, 64'd0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].isDmi, vecs[i].shiftIn, out);
         checkOutput({vecs[i].name, "_tdo"}, out, vecs[i].expOut);
         checkOutput({vecs[i].name, "_valid"}, {63'd0, reqValid}, {63'd0, vecs[i].expValid});
         if (vecs[i].expValid) begin
            checkOutput({vecs[i].name, "_op"}, {62'd0, reqOp}, {62'd0, vecs[i].expOp});
            checkOutput({vecs[i].name, "_addr"}, {57'd0, reqAddr}, {57'd0, vecs[i].expAddr});
            checkOutput({vecs[i].name, "_data"}, {32'd0, reqData}, {32'd0, vecs[i].expData});
            handshake();
            checkOutput({vecs[i].name, "_valid_drop"}, {63'd0, reqValid}, 64'd0);
            respond(vecs[i].respDelay, vecs[i].rData, vecs[i].rErr);
         end
      end

      // Busy: a pending read makes captures report busy and later updates get ignored.
      applyStimulus(1, dmiWord(7'h33, 32'h0, 2'd1), out);
      checkOutput("busy_issue_tdo", out, dmiWord(7'h05, 32'hCAFEF00D, 2'd0));
      checkOutput("busy_issue_valid", {63'd0, reqValid}, 64'd1);
      applyStimulus(1, 64'd0, out);
      checkOutput("busy_capture_tdo", out, dmiWord(7'h33, 32'hCAFEF00D, 2'd3));
      applyStimulus(0, 64'd0, out);
      checkOutput("busy_dtmcs_tdo", out, 64'h1C71);
      applyStimulus(1, dmiWord(7'h44, 32'h55, 2'd2), out);
      checkOutput("busy_ignored_tdo", out, dmiWord(7'h33, 32'hCAFEF00D, 2'd3));
      checkOutput("busy_ignored_op", {62'd0, reqOp}, 64'd1);
      checkOutput("busy_ignored_addr", {57'd0, reqAddr}, 64'h33);
      applyStimulus(0, 64'h10000, out);
      checkOutput("busy_clear_tdo", out, 64'h1C71);
      handshake();
      respond(1, 32'h0BADF00D, 1'b0);
      applyStimulus(1, 64'd0, out);
      checkOutput("busy_after_tdo", out, dmiWord(7'h33, 32'h0BADF00D, 2'd0));

      // Hard reset while a write is still waiting for ready.
      applyStimulus(1, dmiWord(7'h06, 32'h11111111, 2'd2), out);
      checkOutput("hard_issue_valid", {63'd0, reqValid}, 64'd1);
      applyStimulus(0, 64'h30000, out);
      checkOutput("hard_dtmcs_tdo", out, 64'h1071);
      checkOutput("hard_valid_drop", {63'd0, reqValid}, 64'd0);
      respond(0, 32'hFFFFFFFF, 1'b1);
      applyStimulus(1, 64'd0, out);
      checkOutput("hard_idle_tdo", out, dmiWord(7'h06, 32'h11111111, 2'd0));

`ifdef DMI_TIMEOUT_EN
      applyStimulus(1, dmiWord(7'h01, 32'h0, 2'd1), out);
      checkOutput("timeout_issue_valid", {63'd0, reqValid}, 64'd1);
      handshake();
      repeat (8) tick();
      applyStimulus(1, 64'd0, out);
      checkOutput("timeout_status_tdo", out, dmiWord(7'h01, 32'h11111111, 2'd2));
      respond(0, 32'h77, 1'b0);
      applyStimulus(1, 64'd0, out);
      checkOutput("timeout_late_tdo", out, dmiWord(7'h01, 32'h11111111, 2'd2));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmi_jtag_dr.md
Name: dmi_jtag_dr

Overview:
- DTM data-register stage directly downstream of the JTAG TAP.
- Consumes the TAP's capture/shift/update strobes, TDI and the DTMCS/DMI select lines.
- Implements the 32-bit DTMCS register and the (AddrWidth+34)-bit DMI access register, and returns the DTMCS/DMI TDO bits to the TAP.
- Converts DMI updates into valid/ready DMI requests toward the debug module (via a CDC FIFO), tracks the response and keeps the sticky dmistat error.

Parameters:
- AddrWidth, 7: DMI address width; reported as DTMCS.abits.
- IdleCycles, 1: value reported in DTMCS.idle (3 bits; saturates at 7).
- TimeoutCycles, 1024: response watchdog limit; used only with DMI_TIMEOUT_EN.

Ports:
- tck_i  in  1  JTAG test clock; single clock domain.
- trst_i  in  1  reset, synchronous, active-high.
- capture_i  in  1  TAP capture_dr strobe.
- shift_i  in  1  TAP shift_dr strobe.
- update_i  in  1  TAP update_dr strobe.
- tdi_i  in  1  JTAG TDI.
- dtmcs_select_i  in  1  IR selects DTMCS.
- dmi_select_i  in  1  IR selects DMIACCESS.
- dtmcs_tdo_o  out  1  DTMCS shift LSB.
- dmi_tdo_o  out  1  DMI shift LSB.
- dmi_req_valid_o  out  1  request valid.
- dmi_req_ready_i  in  1  request accepted.
- dmi_req_addr_o  out  AddrWidth  request address.
- dmi_req_data_o  out  32  write data.
- dmi_req_op_o  out  2  1=read, 2=write.
- dmi_resp_valid_i  in  1  response valid.
- dmi_resp_ready_o  out  1  constant 1.
- dmi_resp_data_i  in  32  read data.
- dmi_resp_err_i  in  1  debug-module reported failure.

Behaviour:
- Reset (synchronous on trst_i):
  - FSM to Idle; error_q=0; addr_q=0; data_q=0; both shift regs 0.
  - dmi_req_valid_o=0; dmi_resp_ready_o=1; both TDO outputs 0.
- Register actions act on the selected register only; strobes with neither select are ignored.
- DTMCS register:
  - Capture loads {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle[2:0], dmistat=error_q[1:0], abits[5:0]=AddrWidth, version[3:0]=1}.
  - Shift: sr <= {tdi_i, sr[31:1]}.
  - Update with bit16=1: error_q<=0.
  - Update with bit17=1: FSM to Idle, dmi_req_valid_o dropped, error_q<=0.
  - When bits 16 and 17 are set in the same update, both actions occur.
- DMI register, layout {addr, data[31:0], op[1:0]}:
  - Capture loads {addr_q, data_q, error_q}.
  - Capture while FSM≠Idle: load status 3 and set error_q<=3 (busy).
  - Shift: LSB first, same form as DTMCS.
- DMI update:
  - error_q≠0: whole update ignored.
  - FSM≠Idle: error_q<=3; request unchanged.
  - op=1: latch addr → Read.
  - op=2: latch addr and data → Write.
  - op=0 or 3: no action.
- FSM states: Idle, Read, WaitRead, Write, WaitWrite.
  - Read/Write: dmi_req_valid_o=1 with registered addr/data/op; stable until dmi_req_ready_i.
  - Request handshake moves Read→WaitRead and Write→WaitWrite.
  - Latency: update edge → dmi_req_valid_o high next cycle.
  - WaitRead + resp_valid: data_q<=resp_data → Idle.
  - WaitWrite + resp_valid: response data discarded → Idle.
  - In either wait state, resp_err=1 sets error_q<=2 (failed).
  - Responses arriving outside wait states are dropped.
- Simultaneous events:
  - Response and capture in the same cycle: capture sees busy; the response still completes.
  - Update in the cycle the FSM returns to Idle: treated as busy, since the state check uses the registered state.
- error_q encoding: 0 = ok, 2 = failed, 3 = busy. The first error sticks; a later error never overwrites it.
- TDO outputs are combinational from the shift-register LSBs; the TAP registers them on the negative edge.

Optional Feature:
- Macro: DMI_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering WaitRead or WaitWrite and increments each wait cycle.
  - On reaching TimeoutCycles-1 without a response: error_q<=2 (if 0) and FSM → Idle.
  - A late response is then dropped.
- Undefined: no counter; wait states last indefinitely, and only dmihardreset escapes them.

Decomposition:
- Package dm_dtm_pkg holds:
  - dtm_op_e (Nop/Read/Write/Rsvd).
  - dmi_status_e (Ok=0, Failed=2, Busy=3).
  - dtm_state_e.
  - DtmcsVersion=4'd1.
  - DTMCS bit-index constants (DmiReset=16, DmiHardReset=17).
- One sub-module: dtm_shift_reg, a width-parameterised capture/shift register with parallel load, serial in and LSB out. It is instantiated twice.

Test Plan:
- DTMCS capture with AddrWidth=7, IdleCycles=1, reset state → 32 shifted bits read 0x00001071.
- DMI write: shift {addr=0x10, data=0x00000001, op=2}, update → next cycle req_valid=1 with addr 0x10, data 0x1, op 2. Then ready, resp err=0 → following capture returns op field 0.
- DMI read: op=1 addr 0x11, resp_data 0xDEADBEEF after 5 cycles → next capture shifts out data 0xDEADBEEF, status 0.
- Busy path: issue read, hold resp_valid=0, capture DMI → status 3 and DTMCS dmistat=3. New updates are ignored until DTMCS update with bit16=1; status 0 afterwards.
- resp_err=1 on a write → dmistat=2. DTMCS update with bit17=1 during a pending request → req_valid drops next cycle and the FSM is Idle.
- With DMI_TIMEOUT_EN and TimeoutCycles=8, hold resp_valid=0 → FSM Idle after 8 wait cycles, dmistat=2. A later resp_valid pulse changes nothing.
